// File: rtl/mini_2.sv
// Registered 4-bit code converter: b loads f(a) each clock, where MODE selects
// Gray encode/decode, excess-3, two's-complement negate or bit reversal.
module mini_2 #(
    parameter int MODE = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] a,
    output logic [3:0] b
);

    logic [3:0] b_d;
    logic [3:0] b_q;

    // Unlisted MODE values fall back to binary-to-Gray.
    always_comb begin
        b_d = {a[3], a[3] ^ a[2], a[2] ^ a[1], a[1] ^ a[0]};
        case (MODE)
            1: begin
                b_d[3] = a[3];
                b_d[2] = a[3] ^ a[2];
                b_d[1] = a[3] ^ a[2] ^ a[1];
                b_d[0] = a[3] ^ a[2] ^ a[1] ^ a[0];
            end
            2:       b_d = a + 4'd3;
            3:       b_d = ~a + 4'd1;
            4:       b_d = {a[0], a[1], a[2], a[3]};
            default: b_d = {a[3], a[3] ^ a[2], a[2] ^ a[1], a[1] ^ a[0]};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_q <= 4'b0000;
        end else begin
            b_q <= b_d;
        end
    end

    assign b = b_q;

endmodule

// File: tb/tb_mini_2.sv
// Bench for mini_2: one instance per mode plus a Gray encode/decode chain,
// all fed from a shared input and compared against an arithmetic model.
module tb_mini_2;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b0, b1, b2, b3, b4, b7, b_rt;

    int total = 0;
    int bad   = 0;

    logic [3:0] prev_a;
    bit         have_prev;

    mini_2 #(.MODE(0)) u_m0 (.clk(clk), .rst(rst), .a(a),  .b(b0));
    mini_2 #(.MODE(1)) u_m1 (.clk(clk), .rst(rst), .a(a),  .b(b1));
    mini_2 #(.MODE(2)) u_m2 (.clk(clk), .rst(rst), .a(a),  .b(b2));
    mini_2 #(.MODE(3)) u_m3 (.clk(clk), .rst(rst), .a(a),  .b(b3));
    mini_2 #(.MODE(4)) u_m4 (.clk(clk), .rst(rst), .a(a),  .b(b4));
    mini_2 #(.MODE(7)) u_m7 (.clk(clk), .rst(rst), .a(a),  .b(b7));
    mini_2 #(.MODE(1)) u_rt (.clk(clk), .rst(rst), .a(b0), .b(b_rt));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] gray_of(input int v);
        return 4'((v ^ (v >> 1)) % 16);
    endfunction

    // Reference: Gray decode is found by searching the encoder's inverse.
    function automatic logic [3:0] model(input int mode, input logic [3:0] v);
        logic [3:0] r;
        int         x;
        x = int'(v);
        r = 4'd0;
        case (mode)
            1: for (int k = 0; k < 16; k++) if (gray_of(k) == v) r = 4'(k);
            2: r = 4'((x + 3) % 16);
            3: r = 4'((16 - x) % 16);
            4: for (int k = 0; k < 4; k++) r[k] = v[3 - k];
            default: r = gray_of(x);
        endcase
        return r;
    endfunction

    task automatic check_val(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_output();
        check_val("mode0", b0, model(0, a));
        check_val("mode1", b1, model(1, a));
        check_val("mode2", b2, model(2, a));
        check_val("mode3", b3, model(3, a));
        check_val("mode4", b4, model(4, a));
        check_val("mode7", b7, model(7, a));
        if (have_prev) check_val("roundtrip", b_rt, prev_a);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_b0"}, b0, 4'd0);
        check_val({tag, "_b1"}, b1, 4'd0);
        check_val({tag, "_b2"}, b2, 4'd0);
        check_val({tag, "_b3"}, b3, 4'd0);
        check_val({tag, "_b4"}, b4, 4'd0);
        check_val({tag, "_b7"}, b7, 4'd0);
        check_val({tag, "_rt"}, b_rt, 4'd0);
    endtask

    task automatic apply_stimulus(input logic [3:0] val);
        @(negedge clk);
        a = val;
        @(posedge clk);
        #1;
        check_output();
        prev_a    = val;
        have_prev = 1'b1;
    endtask

    logic [3:0] gray_tab [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                  4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

    initial begin
        rst       = 1'b1;
        a         = 4'd0;
        prev_a    = 4'd0;
        have_prev = 1'b0;
        #1;
        check_all_zero("reset_init");
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_held");
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] Gray sweep with round trip");
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(4'(i));
            check_val("gray_table", b0, gray_tab[i]);
        end

        $display("[TB] directed vectors");
        apply_stimulus(4'd8);  check_val("g2b_8",  b1, 4'd15);
        apply_stimulus(4'd13); check_val("g2b_13", b1, 4'd9);
        check_val("xs3_13", b2, 4'd0);
        apply_stimulus(4'd5);  check_val("g2b_5",  b1, 4'd6);
        apply_stimulus(4'd0);  check_val("xs3_0",  b2, 4'd3);
        check_val("neg_0", b3, 4'd0);
        apply_stimulus(4'd9);  check_val("xs3_9",  b2, 4'd12);
        apply_stimulus(4'd15); check_val("xs3_15", b2, 4'd2);
        apply_stimulus(4'd1);  check_val("neg_1",  b3, 4'd15);
        check_val("rev_1", b4, 4'b1000);
        apply_stimulus(4'd8);  check_val("neg_8",  b3, 4'd8);
        apply_stimulus(4'b1100); check_val("rev_12", b4, 4'b0011);

        $display("[TB] reset mid-stream");
        apply_stimulus(4'd7);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("reset_async");
        @(posedge clk);
        #1;
        check_all_zero("reset_edge");
        @(negedge clk);
        rst       = 1'b0;
        have_prev = 1'b0;
        @(posedge clk);
        #1;
        check_val("reset_release", b0, 4'd4);
        check_output();
        prev_a    = a;
        have_prev = 1'b1;

        $display("[TB] random stream");
        for (int i = 0; i < 60; i++) begin
            apply_stimulus(4'($urandom_range(15, 0)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
